upper_ctrl: RTL and testbench

//   Sequencer for the U-type (LUI/AUIPC) datapath unit. Accepts one instruction per

---
 rtl/upper_ctrl_if.sv | 35 +++
 rtl/upper_ctrl.sv | 97 +++++++++
 tb/tb_upper_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/upper_ctrl_if.sv
// Signal bundle between instruction decode, the U-type datapath unit and the
// register-file writeback port; the controller sits on the slave side.
interface upper_ctrl_if #(
    parameter int XLEN = 32
);
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            stall;
    logic            flush;
    logic            up_en;
    logic            up_stall;
    logic            up_pc_sel;
    logic [XLEN-1:0] up_imm;
    logic [XLEN-1:0] up_pc;
    logic [XLEN-1:0] up_reg;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal;

    modport slave (
        input  inst_valid, inst, pc, stall, flush, up_reg, wb_ready,
        output inst_ready, up_en, up_stall, up_pc_sel, up_imm, up_pc,
               wb_valid, wb_rd, wb_data, illegal
    );

    modport master (
        output inst_valid, inst, pc, stall, flush, up_reg, wb_ready,
        input  inst_ready, up_en, up_stall, up_pc_sel, up_imm, up_pc,
               wb_valid, wb_rd, wb_data, illegal
    );
endinterface

// File: rtl/upper_ctrl.sv
// Sequencer for the LUI/AUIPC datapath unit: accepts one instruction, runs the
// unit for one (possibly stalled) cycle, then hands the result to writeback.
module upper_ctrl #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    upper_ctrl_if.slave bus
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WB
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   pc_q;
    logic              pc_sel_q;
    logic              illegal_q;

    logic [6:0]        opcode;
    logic              is_u;
    logic              accept;
    logic signed [31:0] u_imm;
    logic [XLEN-1:0]   imm_ext;

    assign opcode  = bus.inst[6:0];
    assign is_u    = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign u_imm   = signed'({bus.inst[31:12], 12'b0});
    assign imm_ext = XLEN'(u_imm);

    // A flush in IDLE blocks acceptance so the squash really wins over the handshake.
    assign bus.inst_ready = (state == IDLE) && !bus.flush;
    assign accept         = bus.inst_valid && bus.inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_q      <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            pc_sel_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            illegal_q <= accept && !is_u;
            if (accept && is_u) begin
                rd_q     <= bus.inst[11:7];
                imm_q    <= imm_ext;
                pc_q     <= bus.pc;
                pc_sel_q <= (opcode == OP_AUIPC);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_u) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                // Writes to x0 are discarded, so skip the writeback handshake entirely.
                if (!bus.stall) begin
                    state_next = (rd_q != 5'd0) ? WB : IDLE;
                end
            end
            WB: begin
                if (bus.wb_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
        end
    end

    assign bus.up_en     = (state == CALC);
    assign bus.up_stall  = bus.stall;
    assign bus.up_pc_sel = pc_sel_q;
    assign bus.up_imm    = imm_q;
    assign bus.up_pc     = pc_q;
    assign bus.wb_valid  = (state == WB);
    assign bus.wb_rd     = rd_q;
    assign bus.wb_data   = (state == WB) ? bus.up_reg : '0;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_upper_ctrl.sv
// Bench for upper_ctrl: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a transaction-level model.
module tb_upper_ctrl;
    localparam logic [6:0] LUI   = 7'h37;
    localparam logic [6:0] AUIPC = 7'h17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    upper_ctrl_if #(.XLEN(32)) intf ();

    upper_ctrl #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    always #5 clk = ~clk;

    // Stand-in for the datapath unit: captures its result whenever enabled and not stalled.
    always @(posedge clk) begin
        if (rst) begin
            intf.up_reg <= '0;
        end else if (intf.up_en && !intf.up_stall) begin
            intf.up_reg <= intf.up_pc_sel ? (intf.up_pc + intf.up_imm) : intf.up_imm;
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        sel;
        logic        done;
        logic [31:0] res;
    } op_t;

    op_t  ops[$];
    logic m_illegal = 1'b0;

    function automatic logic [31:0] mkInst(input logic [6:0] op, input logic [4:0] rd,
                                           input logic [19:0] imm20);
        return {imm20, rd, op};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic st, input logic fl, input logic wbr,
                                 input logic r);
        @(posedge clk);
        #1;
        intf.inst_valid = v;
        intf.inst       = inst;
        intf.pc         = pc;
        intf.stall      = st;
        intf.flush      = fl;
        intf.wb_ready   = wbr;
        rst             = r;
        @(negedge clk);
    endtask

    // Reference model: at most one op in flight, first computed, then written back.
    initial begin
        op_t cur;
        forever begin
            @(posedge clk);
            if (rst) begin
                ops.delete();
                m_illegal = 1'b0;
            end else begin
                m_illegal = 1'b0;
                if (intf.flush) begin
                    ops.delete();
                end else if (ops.size() != 0) begin
                    cur = ops.pop_front();
                    if (!cur.done) begin
                        if (intf.stall) begin
                            ops.push_front(cur);
                        end else if (cur.rd != 5'd0) begin
                            cur.done = 1'b1;
                            cur.res  = cur.sel ? cur.pc + cur.imm : cur.imm;
                            ops.push_front(cur);
                        end
                    end else if (!intf.wb_ready) begin
                        ops.push_front(cur);
                    end
                end else if (intf.inst_valid) begin
                    if (intf.inst[6:0] == LUI || intf.inst[6:0] == AUIPC) begin
                        cur.rd   = intf.inst[11:7];
                        cur.imm  = {intf.inst[31:12], 12'b0};
                        cur.pc   = intf.pc;
                        cur.sel  = (intf.inst[6:0] == AUIPC);
                        cur.done = 1'b0;
                        cur.res  = '0;
                        ops.push_back(cur);
                    end else begin
                        m_illegal = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic busy;
        logic calc;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                busy = (ops.size() != 0);
                calc = busy && !ops[0].done;
                checkOutput("inst_ready", 32'(intf.inst_ready), 32'(!busy && !intf.flush));
                checkOutput("up_en", 32'(intf.up_en), 32'(calc));
                checkOutput("wb_valid", 32'(intf.wb_valid), 32'(busy && ops[0].done));
                checkOutput("up_stall", 32'(intf.up_stall), 32'(intf.stall));
                checkOutput("illegal", 32'(intf.illegal), 32'(m_illegal));
                if (calc) begin
                    checkOutput("up_pc_sel", 32'(intf.up_pc_sel), 32'(ops[0].sel));
                    checkOutput("up_imm", intf.up_imm, ops[0].imm);
                    checkOutput("up_pc", intf.up_pc, ops[0].pc);
                end
                if (busy && ops[0].done) begin
                    checkOutput("wb_rd", 32'(intf.wb_rd), 32'(ops[0].rd));
                    checkOutput("wb_data", intf.wb_data, ops[0].res);
                end
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [31:0] inst;
        logic [6:0]  op;
        logic [4:0]  rd;
        int          sel;

        intf.inst_valid = 1'b0;
        intf.inst       = '0;
        intf.pc         = '0;
        intf.stall      = 1'b0;
        intf.flush      = 1'b0;
        intf.wb_ready   = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_ready", 32'(intf.inst_ready), 32'd1);
        checkOutput("rst_wb_valid", 32'(intf.wb_valid), 32'd0);
        checkOutput("rst_up_en", 32'(intf.up_en), 32'd0);

        applyStimulus(1, mkInst(LUI, 5, 20'h12345), 32'h0, 0, 0, 0, 0);
        checkOutput("lui_ready", 32'(intf.inst_ready), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("lui_en", 32'(intf.up_en), 32'd1);
        checkOutput("lui_sel", 32'(intf.up_pc_sel), 32'd0);
        checkOutput("lui_imm", intf.up_imm, 32'h12345000);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("lui_en_once", 32'(intf.up_en), 32'd0);
        checkOutput("lui_wb_rd", 32'(intf.wb_rd), 32'd5);
        checkOutput("lui_wb_data", intf.wb_data, 32'h12345000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("lui_idle", 32'(intf.inst_ready), 32'd1);

        applyStimulus(1, mkInst(AUIPC, 7, 20'h00001), 32'h1000, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("auipc_sel", 32'(intf.up_pc_sel), 32'd1);
        checkOutput("auipc_pc", intf.up_pc, 32'h1000);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("auipc_wb_data", intf.wb_data, 32'h00002000);
        checkOutput("auipc_wb_rd", 32'(intf.wb_rd), 32'd7);

        applyStimulus(1, mkInst(AUIPC, 3, 20'h00001), 32'hFFFFF000, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("wrap_wb_data", intf.wb_data, 32'h0);
        checkOutput("wrap_wb_valid", 32'(intf.wb_valid), 32'd1);

        applyStimulus(1, mkInst(LUI, 9, 20'hABCDE), 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("stall_en1", 32'(intf.up_en), 32'd1);
        checkOutput("stall_out", 32'(intf.up_stall), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        checkOutput("stall_en2", 32'(intf.up_en), 32'd1);
        checkOutput("stall_no_wb", 32'(intf.wb_valid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_en3", 32'(intf.up_en), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("stall_wb_data", intf.wb_data, 32'hABCDE000);

        applyStimulus(1, mkInst(LUI, 12, 20'h00042), 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, i[0], 0, 0, 0);
            checkOutput("hold_valid", 32'(intf.wb_valid), 32'd1);
            checkOutput("hold_rd", 32'(intf.wb_rd), 32'd12);
            checkOutput("hold_data", intf.wb_data, 32'h00042000);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("hold_final_data", intf.wb_data, 32'h00042000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("hold_idle", 32'(intf.inst_ready), 32'd1);

        applyStimulus(1, mkInst(LUI, 0, 20'h55555), 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("x0_en", 32'(intf.up_en), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("x0_no_wb", 32'(intf.wb_valid), 32'd0);
        checkOutput("x0_ready", 32'(intf.inst_ready), 32'd1);

        applyStimulus(1, 32'h00100093, 32'h0, 0, 0, 0, 0);
        checkOutput("ill_ready", 32'(intf.inst_ready), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ill_pulse", 32'(intf.illegal), 32'd1);
        checkOutput("ill_no_en", 32'(intf.up_en), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ill_pulse_end", 32'(intf.illegal), 32'd0);

        applyStimulus(1, mkInst(LUI, 8, 20'h11111), 32'h0, 0, 1, 0, 0);
        checkOutput("flush_idle_ready", 32'(intf.inst_ready), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_idle_no_en", 32'(intf.up_en), 32'd0);

        applyStimulus(1, mkInst(LUI, 4, 20'h22222), 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("flush_wb_valid", 32'(intf.wb_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("flush_wb_gone", 32'(intf.wb_valid), 32'd0);
        checkOutput("flush_wb_ready", 32'(intf.inst_ready), 32'd1);

        applyStimulus(1, mkInst(LUI, 6, 20'h33333), 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("rst_calc_en", 32'(intf.up_en), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("rst_calc_idle", 32'(intf.inst_ready), 32'd1);
        checkOutput("rst_calc_no_wb", 32'(intf.wb_valid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("rst_calc_no_wb2", 32'(intf.wb_valid), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 3);
            r   = $urandom;
            op  = (sel == 0) ? LUI : (sel == 1) ? AUIPC : (sel == 2) ? 7'h13 : r[6:0];
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            inst = {r[31:12], rd, op};
            applyStimulus($urandom_range(0, 1) == 1, inst, $urandom,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
